// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-only channel bundle (AR + R) between the arbiter and the memory port.
interface axi_rd_arbiter_if #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned WIDTH_IN_BYTES = 64,
    parameter int unsigned ID_WIDTH       = 16
);
    logic [ID_WIDTH-1:0]         arid;
    logic [ADDR_WIDTH-1:0]       araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;
    logic [ID_WIDTH-1:0]         rid;
    logic [WIDTH_IN_BYTES*8-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between N_REQ requesters, one whole burst
// at a time, with sticky checks on response, ID and burst length.
module axi_rd_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned WIDTH_IN_BYTES = 64,
    parameter int unsigned ID_WIDTH       = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_araddr,
    input  logic [N_REQ*8-1:0]            req_arlen,
    input  logic [N_REQ-1:0]              req_arvalid,
    output logic [N_REQ-1:0]              req_arready,
    output logic [WIDTH_IN_BYTES*8-1:0]   req_rdata,
    output logic                          req_rlast,
    output logic [N_REQ-1:0]              req_rvalid,
    input  logic [N_REQ-1:0]              req_rready,
    axi_rd_arbiter_if.master              m,
    output logic                          busy,
    output logic                          err_resp,
    output logic                          err_id,
    output logic                          err_len,
    input  logic                          err_clear
);
    localparam int unsigned GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0]  ARSIZE = 3'($clog2(WIDTH_IN_BYTES));

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic            rr_found;
    logic [31:0]     rr_idx;
    logic [7:0]      len_q;
    logic [8:0]      beat_cnt;
    logic            r_hs;
    logic            at_len;

    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [7:0]            len_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_arr[i] = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[i]  = req_arlen[i*8 +: 8];
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        winner   = last_grant;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            rr_idx = 32'(last_grant) + k;
            if (rr_idx >= N_REQ) begin
                rr_idx = rr_idx - N_REQ;
            end
            if (!rr_found && req_arvalid[rr_idx]) begin
                winner   = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    assign r_hs   = (state == StData) && m.rvalid && m.rready;
    assign at_len = (beat_cnt == {1'b0, len_q});

    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        if (state == StAddr) begin
            req_arready[grant] = m.arready;
        end
        if (state == StData) begin
            req_rvalid[grant] = m.rvalid;
        end
    end

    assign m.arvalid = (state == StAddr);
    assign m.araddr  = addr_arr[grant];
    assign m.arlen   = len_arr[grant];
    assign m.arid    = ID_WIDTH'(grant);
    assign m.arsize  = ARSIZE;
    assign m.arburst = 2'b01;
    assign m.rready  = (state == StData) && req_rready[grant];
    assign req_rdata = m.rdata;
    assign req_rlast = m.rlast;
    assign busy      = (state != StIdle);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= StIdle;
            grant      <= '0;
            last_grant <= GW'(N_REQ - 1);
            len_q      <= '0;
            beat_cnt   <= '0;
            err_resp   <= 1'b0;
            err_id     <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            if (err_clear) begin
                err_resp <= 1'b0;
                err_id   <= 1'b0;
                err_len  <= 1'b0;
            end
            // Later assignments override the clear, so a same-cycle error stays set.
            if (r_hs) begin
                if (m.rresp != 2'b00) begin
                    err_resp <= 1'b1;
                end
                if (m.rid != ID_WIDTH'(grant)) begin
                    err_id <= 1'b1;
                end
                if (m.rlast != at_len) begin
                    err_len <= 1'b1;
                end
                beat_cnt <= beat_cnt + 9'd1;
            end
            unique case (state)
                StIdle: begin
                    if (rr_found) begin
                        grant    <= winner;
                        len_q    <= len_arr[winner];
                        beat_cnt <= '0;
                        state    <= StAddr;
                    end
                end
                StAddr: begin
                    if (m.arready) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (r_hs && m.rlast) begin
                        last_grant <= grant;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares one AXI4 read master port (AR and R channels of the `axi_if` master modport) between `N_REQ` requesters, such as PairHMM workers fetching reads and haplotypes from DDR. The arbiter serialises whole bursts: it grants one requester, forwards its AR, then routes R beats back to that requester until `rlast`. It also checks burst length, ID and response, and reports errors through sticky flags.

## Interface
- `N_REQ`, default 4: number of requesters (2..16).
- `ADDR_WIDTH`, default 64: AXI address width.
- `WIDTH_IN_BYTES`, default 64: AXI data width in bytes (power of 2).
- `ID_WIDTH`, default 16: AXI ID width; must satisfy `ID_WIDTH ≥ $clog2(N_REQ)`.

Ports:
- `aclk` in 1: single clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `req_araddr` in N_REQ*ADDR_WIDTH: per-requester burst address; slice i belongs to requester i.
- `req_arlen` in N_REQ*8: per-requester AXI burst length (beats−1).
- `req_arvalid` in N_REQ: per-requester request valid.
- `req_arready` out N_REQ: per-requester request accepted.
- `req_rdata` out WIDTH_IN_BYTES*8: read data, broadcast to all requesters.
- `req_rlast` out 1: last beat, broadcast.
- `req_rvalid` out N_REQ: beat valid, one-hot to the granted requester.
- `req_rready` in N_REQ: per-requester ready.
- `m_arid`, `m_araddr`, `m_arlen`, `m_arsize`, `m_arburst`, `m_arvalid` out: AXI AR channel to memory.
- `m_arready` in 1: AXI AR ready.
- `m_rid`, `m_rdata`, `m_rresp`, `m_rlast`, `m_rvalid` in: AXI R channel.
- `m_rready` out 1: AXI R ready.
- `busy` out 1: high when the FSM is not IDLE.
- `err_resp` out 1: sticky; an R beat arrived with `m_rresp != 0`.
- `err_id` out 1: sticky; an R beat arrived with `m_rid` not equal to the issued ID.
- `err_len` out 1: sticky; `m_rlast` position did not match `arlen+1`.
- `err_clear` in 1: synchronous clear of all sticky errors.

## Operation
- FSM has three states: IDLE, ADDR, DATA.
- **IDLE**
  - If any `req_arvalid` is high, select a winner `g` by round-robin, searching from `last_grant+1` modulo N_REQ.
  - Register `g`, latch `req_arlen[g]` into `len_q`, clear the beat counter, then go to ADDR.
  - No request: stay in IDLE.
- **ADDR**
  - `m_arvalid` = 1.
  - `m_araddr` = `req_araddr[g]` and `m_arlen` = `req_arlen[g]` (combinational from the held requester slice).
  - `m_arid` = `g`, zero-extended. `m_arsize` = `$clog2(WIDTH_IN_BYTES)`. `m_arburst` = 2'b01 (INCR).
  - `req_arready[g]` = `m_arready`; all other `req_arready` bits are 0.
  - On `m_arready`: go to DATA.
  - Requesters must hold `arvalid`, `araddr` and `arlen` stable until `arready`, per AXI rules.
- **DATA**
  - `req_rvalid[g]` = `m_rvalid`; `m_rready` = `req_rready[g]`; `req_rdata` = `m_rdata`; `req_rlast` = `m_rlast`.
  - Each handshake (`m_rvalid & m_rready`) increments the 9-bit beat counter.
  - On a handshake with `m_rlast`: set `last_grant` = `g` and go to IDLE.
- **Error checks, evaluated on each R handshake**
  - `rresp != 0` → set `err_resp`.
  - `rid != g` → set `err_id`.
  - `m_rlast` with counter ≠ `len_q` → set `err_len` (early `rlast`).
  - Counter == `len_q` without `m_rlast` → set `err_len` and keep routing until `rlast` (late `rlast`).
  - A set and a `err_clear` in the same cycle: set wins.
- **Outputs while not in the owning state**
  - Outside ADDR: `m_arvalid` = 0 and `req_arready` = 0.
  - Outside DATA: `m_rready` = 0 and `req_rvalid` = 0.
  - R beats arriving in IDLE/ADDR are not accepted (`m_rready` = 0).
- **Reset (asynchronous, any time including mid-burst)**
  - FSM → IDLE; `last_grant` = N_REQ−1, so requester 0 wins first; counter = 0; all error flags = 0.
  - All valid/ready outputs are 0 and `busy` = 0.
  - A burst interrupted by reset is abandoned; memory-side recovery is the system's responsibility.

## Timing
- Arbitration latency: a `req_arvalid` seen in IDLE at cycle t gives `m_arvalid` = 1 at t+1.
- AR pass-through is combinational: `req_arready[g]` rises in the same cycle as `m_arready`.
- R path is combinational, with zero added latency on data, valid and ready.
- The FSM returns to IDLE the cycle after the `rlast` handshake, so there is at least one dead cycle between bursts.
- Best-case cost per burst is arlen+1 beats plus 2 overhead cycles (IDLE + ADDR), plus memory latency.
- Fairness: a continuously requesting requester waits at most N_REQ−1 bursts.
- All registers use the asynchronous reset; no other asynchronous paths exist.

## Test plan
- **Reset defaults:** assert `aresetn` = 0 with all inputs active → all `req_arready`, `req_rvalid`, `m_arvalid`, `m_rready`, `busy` and `err_*` = 0. Release reset with requests 0 and 2 pending → requester 0 is granted first, and `m_arid` = 0 one cycle later.
- **Round-robin:** requesters 0–3 continuously request arlen = 3 → grants go 0,1,2,3,0 in order; each gets exactly 4 `req_rvalid` beats; `m_arsize` = 6 and `m_arburst` = 1 on every AR.
- **Backpressure:** `m_arready` is low for 5 cycles, then `req_rready[g]` toggles every cycle during a 16-beat burst → `m_arvalid` is held with a stable address; exactly 16 beats are transferred; `m_rready` mirrors `req_rready[g]`.
- **Error flags:** memory returns `rresp` = 2 on beat 1, then a later burst with `rid` = 3 while the grant is 1, then `rlast` on beat 2 of an arlen = 7 burst → `err_resp`, `err_id` and `err_len` each set and remain set. Pulse `err_clear` → all three clear.
- **Reset mid-burst:** assert `aresetn` low during beat 5 of 8 → outputs drop immediately, FSM is IDLE. After release the next grant goes to requester 0.
- **Single requester:** requester 2 alone issues back-to-back arlen = 0 bursts → each burst takes 3 cycles minimum (IDLE, ADDR with `m_arready` = 1, one beat).
